// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BEATS  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // One extra bit so the counter can hold MAX_BEATS itself.
  function automatic int beat_cnt_width(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin choice: on a tie the requester that did not win last time wins.
module mem_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two cache controllers onto one simple_mem port, with locked bursts
// capped at MAX_BEATS and a mandatory idle bubble between grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int BW = beat_cnt_width(MAX_BEATS);

  arb_state_t    state_reg, state_next;
  logic          last_grant_reg, last_grant_next;
  logic [BW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [BW-1:0] beat_inc;
  logic          pick_winner, pick_valid;
  logic          sel, sel_req, sel_lock;

  mem_rr_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant_reg),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign beat_inc = beat_cnt_reg + BW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    m0_ready        = 1'b0;
    m0_rdata        = '0;
    m1_ready        = 1'b0;
    m1_rdata        = '0;
    sel             = (state_reg == GNT1);
    sel_req         = sel ? m1_req  : m0_req;
    sel_lock        = sel ? m1_lock : m0_lock;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next      = pick_winner ? GNT1 : GNT0;
          last_grant_next = pick_winner;
          beat_cnt_next   = '0;
        end
      end
      GNT0, GNT1: begin
        mem_req   = sel_req;
        mem_we    = sel ? m1_we    : m0_we;
        mem_addr  = sel ? m1_addr  : m0_addr;
        mem_wdata = sel ? m1_wdata : m0_wdata;
        if (sel) begin
          m1_ready = mem_ready;
          m1_rdata = mem_ready ? mem_rdata : '0;
        end else begin
          m0_ready = mem_ready;
          m0_rdata = mem_ready ? mem_rdata : '0;
        end
        // The beat cap releases even a locked owner so the other side cannot starve.
        if (mem_ready) begin
          beat_cnt_next = beat_inc;
          if (!sel_lock || beat_inc == BW'(MAX_BEATS)) state_next = IDLE;
        end else if (!sel_req && !sel_lock) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle checked against a grant-owner model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req[2], lock[2], we[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];
  logic          rdy[2];
  logic [DW-1:0] rdat[2];
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  // Reference: who owns the memory (-1 none), who won last, beats in this grant.
  int own   = -1;
  bit lastg = 1'b1;
  int beats = 0;

  int            mem_lat = 0, mem_wait = 0;
  bit            spur = 1'b0, rand_spur = 1'b0;
  bit            got[2];
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  int            order[$];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_ready(rdy[0]), .m0_rdata(rdat[0]),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_ready(rdy[1]), .m1_rdata(rdat[1]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; lastg = 1'b1; beats = 0; mem_wait = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_m0_ready"}, 64'(rdy[0]), 64'(0));
    chk({tag, "_m1_ready"}, 64'(rdy[1]), 64'(0));
    chk({tag, "_m0_rdata"}, 64'(rdat[0]), 64'(0));
    chk({tag, "_m1_rdata"}, 64'(rdat[1]), 64'(0));
    chk({tag, "_state"}, 64'(dut.state_reg), 64'(0));
  endtask

  // Called at posedge+1 with requester inputs already set; returns at the next posedge+1.
  task automatic cycle();
    logic          e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rdy[2];
    logic [DW-1:0] e_rdat[2];
    #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (mem_req) begin
      if (mem_wait >= mem_lat) begin
        mem_ready = 1'b1; mem_rdata = $urandom; mem_wait = 0;
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
      if (spur || (rand_spur && $urandom_range(15) == 0)) begin
        mem_ready = 1'b1; mem_rdata = $urandom;
      end
    end
    #1;
    if (mem_req && mem_we) begin w_addr = mem_addr; w_data = mem_wdata; end
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rdat[0] = '0; e_rdat[1] = '0;
    if (own >= 0) begin
      e_req = req[own]; e_we = we[own]; e_addr = addr[own]; e_wdata = wdata[own];
      e_rdy[own]  = mem_ready;
      e_rdat[own] = mem_ready ? mem_rdata : '0;
    end
    chk("mem_req", 64'(mem_req), 64'(e_req));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("m0_ready", 64'(rdy[0]), 64'(e_rdy[0]));
    chk("m1_ready", 64'(rdy[1]), 64'(e_rdy[1]));
    chk("m0_rdata", 64'(rdat[0]), 64'(e_rdat[0]));
    chk("m1_rdata", 64'(rdat[1]), 64'(e_rdat[1]));
    chk("state", 64'(dut.state_reg), 64'(own + 1));
    got[0] = rdy[0];
    got[1] = rdy[1];
    if (own < 0) begin
      if (req[0] && req[1]) own = lastg ? 0 : 1;
      else if (req[0])      own = 0;
      else if (req[1])      own = 1;
      if (own >= 0) begin lastg = (own == 1); beats = 0; end
    end else if (mem_ready) begin
      beats++;
      if (!lock[own] || beats == MB) own = -1;
    end else if (!req[own] && !lock[own]) begin
      own = -1;
    end
    @(posedge clk);
    #1;
  endtask

  // Requesters drop req and lock after their first completed transfer.
  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while ((req[0] || req[1] || lock[0] || lock[1]) && n < budget) begin
      cycle();
      n++;
      for (int i = 0; i < 2; i++)
        if (got[i] && req[i]) begin
          order.push_back(i); req[i] = 1'b0; lock[i] = 1'b0; we[i] = 1'b0;
        end
    end
    chk({tag, "_timeout"}, 64'(req[0] || req[1]), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; lock[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int p0;
    bit m1_done;
    do_reset();

    // Single read by m0, memory answers after two wait cycles.
    mem_lat = 2; req[0] = 1'b1; addr[0] = 32'h10; order.delete();
    run_until_done("c038", 10);
    chk("c038_count", 64'(order.size()), 64'(1));
    if (order.size() == 1) chk("c038_who", 64'(order[0]), 64'(0));
    chk("c038_idle", 64'(dut.state_reg), 64'(0));

    // Simultaneous requests after reset: m0 first, then m1.
    do_reset();
    mem_lat = 0; req[0] = 1'b1; req[1] = 1'b1; addr[0] = 32'h40; addr[1] = 32'h80; order.delete();
    run_until_done("c039", 20);
    chk("c039_count", 64'(order.size()), 64'(2));
    if (order.size() == 2) begin
      chk("c039_first", 64'(order[0]), 64'(0));
      chk("c039_second", 64'(order[1]), 64'(1));
    end

    // Locked 16-beat burst by m0 with m1 waiting.
    req[0] = 1'b1; lock[0] = 1'b1; req[1] = 1'b1; p0 = 0; m1_done = 1'b0;
    for (int n = 0; n < 60 && !m1_done; n++) begin
      cycle();
      if (got[0]) p0++;
      if (got[1]) begin m1_done = 1'b1; req[1] = 1'b0; req[0] = 1'b0; lock[0] = 1'b0; end
    end
    chk("c040_beats", 64'(p0), 64'(MB));
    chk("c040_m1_granted", 64'(m1_done), 64'(1));
    repeat (2) cycle();

    // Locked write by m1, then req and lock dropped together.
    w_addr = '0; w_data = '0; mem_lat = 1;
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hDEADBEEF;
    run_until_done("c041", 20);
    chk("c041_addr", 64'(w_addr), 64'(32'h20));
    chk("c041_wdata", 64'(w_data), 64'(32'hDEADBEEF));
    cycle();
    chk("c041_idle", 64'(dut.state_reg), 64'(0));

    // Reset during the fifth beat of an m1 burst.
    mem_lat = 0; req[1] = 1'b1; lock[1] = 1'b1; p0 = 0;
    for (int n = 0; n < 30 && p0 < 4; n++) begin
      cycle();
      if (got[1]) p0++;
    end
    chk("c042_beats", 64'(p0), 64'(4));
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    check_quiet("c042_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; lock[1] = 1'b0; req[0] = 1'b1; req[1] = 1'b1; order.delete();
    run_until_done("c042", 20);
    if (order.size() == 2) chk("c042_tie", 64'(order[0]), 64'(0));
    else chk("c042_count", 64'(order.size()), 64'(2));

    // mem_ready in IDLE reaches nobody.
    spur = 1'b1;
    repeat (3) cycle();
    spur = 1'b0;
    chk("c043_idle", 64'(dut.state_reg), 64'(0));

    // Randomized traffic.
    rand_spur = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (got[0] || got[1]) mem_lat = $urandom_range(3);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && got[i]) begin
          if (lock[i] && $urandom_range(3) != 0) begin
            we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
          end else begin
            req[i] = 1'b0; lock[i] = lock[i] && ($urandom_range(3) == 0);
          end
        end else if (!req[i]) begin
          if (lock[i]) begin
            if ($urandom_range(3) == 0) lock[i] = 1'b0;
            else if ($urandom_range(3) == 0) req[i] = 1'b1;
          end else if ($urandom_range(2) == 0) begin
            req[i] = 1'b1; lock[i] = ($urandom_range(2) == 0);
            we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
          end
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0; lock[i] = 1'b0;
        end
      end
    end
    rand_spur = 1'b0;
    for (int i = 0; i < 2; i++) begin req[i] = 1'b0; lock[i] = 1'b0; end
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
